// File: rtl/cpu_io_peripheral.sv
// Purpose : far-end CPU I/O device; input FIFO feeding the CPU input_port with an
//           arrival interrupt, output FIFO capturing CPU OUT writes for an external consumer.
// Latency : 1 cycle from a push/write edge to visibility on input_port / ext_out_*;
//           interrupt rises the cycle after the first push into an empty input FIFO.
// Backpressure: ext_in_ready drops when the input FIFO is full; CPU writes into a
//           full output FIFO (with no simultaneous drain) are dropped and flagged sticky.
//
// Ports:
//   clk, reset          clock, async active-low reset
//   ext_in_*            valid/ready byte stream from the external source
//   input_port, in_rd   head of the input FIFO to the CPU, one-cycle pop strobe
//   interrupt           IRQ_CYCLES-wide pulse per empty->non-empty input burst
//   cpu_out, out_wr     CPU OUT byte and its one-cycle capture strobe
//   ext_out_*           valid/ready byte stream to the external consumer
//   in_count            input FIFO occupancy
//   out_overflow        sticky: a CPU write was dropped
module cpu_io_peripheral #(
  parameter int IN_DEPTH   = 4,
  parameter int OUT_DEPTH  = 4,
  parameter int IRQ_CYCLES = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [7:0]                ext_in_data,
  input  logic                      ext_in_valid,
  output logic                      ext_in_ready,
  output logic [7:0]                input_port,
  input  logic                      in_rd,
  output logic                      interrupt,
  input  logic [7:0]                cpu_out,
  input  logic                      out_wr,
  output logic [7:0]                ext_out_data,
  output logic                      ext_out_valid,
  input  logic                      ext_out_ready,
  output logic [$clog2(IN_DEPTH):0] in_count,
  output logic                      out_overflow
);

  localparam int IN_AW  = $clog2(IN_DEPTH);
  localparam int OUT_AW = $clog2(OUT_DEPTH);
  localparam int IRQ_W  = $clog2(IRQ_CYCLES + 1);

  localparam logic [IN_AW:0]    IN_FULL  = (IN_AW + 1)'(IN_DEPTH);
  localparam logic [OUT_AW:0]   OUT_FULL = (OUT_AW + 1)'(OUT_DEPTH);
  localparam logic [IRQ_W-1:0]  IRQ_LOAD = IRQ_W'(IRQ_CYCLES);
  localparam logic [IRQ_W-1:0]  IRQ_LAST = IRQ_W'(1);

  // ---------------------------------------------------------------------------
  // Input FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]       in_mem [IN_DEPTH];
  logic [IN_AW-1:0] in_wr_ptr;
  logic [IN_AW-1:0] in_rd_ptr;
  logic [IN_AW:0]   in_cnt;
  logic             in_empty;
  logic             in_push;
  logic             in_pop;

  assign in_empty     = (in_cnt == '0);
  // Gated by reset so nothing is accepted while the block is held in reset.
  assign ext_in_ready = reset & (in_cnt != IN_FULL);
  assign in_push      = ext_in_valid & ext_in_ready;
  // A pop on an empty FIFO is ignored, even if a push lands in the same cycle.
  assign in_pop       = in_rd & ~in_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      in_wr_ptr <= '0;
      in_rd_ptr <= '0;
      in_cnt    <= '0;
    end else begin
      if (in_push) in_wr_ptr <= in_wr_ptr + 1'b1;
      if (in_pop)  in_rd_ptr <= in_rd_ptr + 1'b1;
      case ({in_push, in_pop})
        2'b10:   in_cnt <= in_cnt + 1'b1;
        2'b01:   in_cnt <= in_cnt - 1'b1;
        default: in_cnt <= in_cnt;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to 8'h00 whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (in_push) in_mem[in_wr_ptr] <= ext_in_data;
  end

  assign input_port = in_empty ? 8'h00 : in_mem[in_rd_ptr];
  assign in_count   = in_cnt;

  // ---------------------------------------------------------------------------
  // Interrupt FSM
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    IRQ_IDLE  = 2'd0,
    IRQ_PULSE = 2'd1,
    IRQ_WAIT  = 2'd2
  } irq_state_t;

  irq_state_t       irq_state;
  irq_state_t       irq_state_nxt;
  logic [IRQ_W-1:0] irq_cnt;
  logic [IRQ_W-1:0] irq_cnt_nxt;
  logic             first_push;

  assign first_push = in_push & in_empty;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_state <= IRQ_IDLE;
      irq_cnt   <= '0;
    end else begin
      irq_state <= irq_state_nxt;
      irq_cnt   <= irq_cnt_nxt;
    end
  end

  always_comb begin
    irq_state_nxt = irq_state;
    irq_cnt_nxt   = irq_cnt;
    case (irq_state)
      IRQ_IDLE: begin
        if (first_push) begin
          irq_state_nxt = IRQ_PULSE;
          irq_cnt_nxt   = IRQ_LOAD;
        end
      end
      IRQ_PULSE: begin
        // Pulse always runs its full width, even if the CPU drains the FIFO meanwhile.
        irq_cnt_nxt = irq_cnt - 1'b1;
        if (irq_cnt == IRQ_LAST) irq_state_nxt = IRQ_WAIT;
      end
      IRQ_WAIT: begin
        // An empty FIFO here ends the burst; a push into it in the same
        // cycle starts the next burst straight away so its pulse is not lost.
        if (first_push) begin
          irq_state_nxt = IRQ_PULSE;
          irq_cnt_nxt   = IRQ_LOAD;
        end else if (in_empty) begin
          irq_state_nxt = IRQ_IDLE;
        end
      end
      default: begin
        irq_state_nxt = IRQ_IDLE;
        irq_cnt_nxt   = '0;
      end
    endcase
  end

  assign interrupt = (irq_state == IRQ_PULSE);

  // ---------------------------------------------------------------------------
  // Output FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]        out_mem [OUT_DEPTH];
  logic [OUT_AW-1:0] out_wr_ptr;
  logic [OUT_AW-1:0] out_rd_ptr;
  logic [OUT_AW:0]   out_cnt;
  logic              out_full;
  logic              out_rd;
  logic              out_push;

  assign out_full      = (out_cnt == OUT_FULL);
  assign ext_out_valid = (out_cnt != '0);
  assign out_rd        = ext_out_valid & ext_out_ready;
  // A write into a full FIFO is still taken when the head leaves in the same cycle.
  assign out_push      = out_wr & (~out_full | out_rd);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_wr_ptr   <= '0;
      out_rd_ptr   <= '0;
      out_cnt      <= '0;
      out_overflow <= 1'b0;
    end else begin
      if (out_push) out_wr_ptr <= out_wr_ptr + 1'b1;
      if (out_rd)   out_rd_ptr <= out_rd_ptr + 1'b1;
      case ({out_push, out_rd})
        2'b10:   out_cnt <= out_cnt + 1'b1;
        2'b01:   out_cnt <= out_cnt - 1'b1;
        default: out_cnt <= out_cnt;
      endcase
      if (out_wr & ~out_push) out_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (out_push) out_mem[out_wr_ptr] <= cpu_out;
  end

  assign ext_out_data = ext_out_valid ? out_mem[out_rd_ptr] : 8'h00;

endmodule

// File: tb/tb_cpu_io_peripheral.sv
// Directed table-driven bench for cpu_io_peripheral (IN_DEPTH=4, OUT_DEPTH=4, IRQ_CYCLES=2).
module tb_cpu_io_peripheral;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ext_in_data;
  logic       ext_in_valid;
  logic       ext_in_ready;
  logic [7:0] input_port;
  logic       in_rd;
  logic       interrupt;
  logic [7:0] cpu_out;
  logic       out_wr;
  logic [7:0] ext_out_data;
  logic       ext_out_valid;
  logic       ext_out_ready;
  logic [2:0] in_count;
  logic       out_overflow;

  always #5 clk = ~clk;

  cpu_io_peripheral #(
    .IN_DEPTH  (4),
    .OUT_DEPTH (4),
    .IRQ_CYCLES(2)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .ext_in_data  (ext_in_data),
    .ext_in_valid (ext_in_valid),
    .ext_in_ready (ext_in_ready),
    .input_port   (input_port),
    .in_rd        (in_rd),
    .interrupt    (interrupt),
    .cpu_out      (cpu_out),
    .out_wr       (out_wr),
    .ext_out_data (ext_out_data),
    .ext_out_valid(ext_out_valid),
    .ext_out_ready(ext_out_ready),
    .in_count     (in_count),
    .out_overflow (out_overflow)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       rd;
    logic       wr;
    logic [7:0] co;
    logic       ordy;
    logic [7:0] e_ip;
    logic [2:0] e_cnt;
    logic       e_irq;
    logic       e_irdy;
    logic       e_ov;
    logic [7:0] e_od;
    logic       e_oflo;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   passes = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic rd,
                     input logic wr, input logic [7:0] co, input logic ordy,
                     input logic [7:0] ip, input logic [2:0] cnt, input logic irq,
                     input logic irdy, input logic ov, input logic [7:0] od,
                     input logic oflo);
    vec_t t;
    t.v = v; t.d = d; t.rd = rd; t.wr = wr; t.co = co; t.ordy = ordy;
    t.e_ip = ip; t.e_cnt = cnt; t.e_irq = irq; t.e_irdy = irdy;
    t.e_ov = ov; t.e_od = od; t.e_oflo = oflo;
    vecs.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input logic [7:0] ip, input logic [2:0] cnt,
                           input logic irq, input logic irdy, input logic ov,
                           input logic [7:0] od, input logic oflo);
    chk({tag, " input_port"},    int'(input_port),    int'(ip));
    chk({tag, " in_count"},      int'(in_count),      int'(cnt));
    chk({tag, " interrupt"},     int'(interrupt),     int'(irq));
    chk({tag, " ext_in_ready"},  int'(ext_in_ready),  int'(irdy));
    chk({tag, " ext_out_valid"}, int'(ext_out_valid), int'(ov));
    chk({tag, " ext_out_data"},  int'(ext_out_data),  int'(od));
    chk({tag, " out_overflow"},  int'(out_overflow),  int'(oflo));
  endtask

  initial begin
    reset = 1'b0;
    ext_in_data = 8'h00; ext_in_valid = 1'b0; in_rd = 1'b0;
    cpu_out = 8'h00; out_wr = 1'b0; ext_out_ready = 1'b0;

    //   v  d      rd wr co     ordy | ip     cnt irq rdy ov od     oflo
    // single push, 2-cycle pulse, no repeat while unread
    add(1, 8'hFD, 0, 0, 8'h00, 0,   8'hFD, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'hFD, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'hFD, 1, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'hFD, 1, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    // fill to full, held 5th byte stalls until a pop frees a slot
    add(1, 8'h11, 0, 0, 8'h00, 0,   8'h11, 1, 1, 1, 0, 8'h00, 0);
    add(1, 8'h22, 0, 0, 8'h00, 0,   8'h11, 2, 1, 1, 0, 8'h00, 0);
    add(1, 8'h33, 0, 0, 8'h00, 0,   8'h11, 3, 0, 1, 0, 8'h00, 0);
    add(1, 8'h44, 0, 0, 8'h00, 0,   8'h11, 4, 0, 0, 0, 8'h00, 0);
    add(1, 8'h55, 0, 0, 8'h00, 0,   8'h11, 4, 0, 0, 0, 8'h00, 0);
    add(1, 8'h55, 1, 0, 8'h00, 0,   8'h22, 3, 0, 1, 0, 8'h00, 0);
    add(1, 8'h55, 0, 0, 8'h00, 0,   8'h22, 4, 0, 0, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h33, 3, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h44, 2, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h55, 1, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    // new burst after drain -> new pulse; in_rd while empty ignored
    add(1, 8'hA0, 0, 0, 8'h00, 0,   8'hA0, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'hA0, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'hA0, 1, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    // push+pop on empty: pop ignored; drain during pulse keeps full width
    add(1, 8'hB5, 1, 0, 8'h00, 0,   8'hB5, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h00, 0, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    add(0, 8'h00, 0, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    // simultaneous push and pop on non-empty: count unchanged
    add(1, 8'hC1, 0, 0, 8'h00, 0,   8'hC1, 1, 1, 1, 0, 8'h00, 0);
    add(1, 8'hC2, 1, 0, 8'h00, 0,   8'hC2, 1, 1, 1, 0, 8'h00, 0);
    add(0, 8'h00, 1, 0, 8'h00, 0,   8'h00, 0, 0, 1, 0, 8'h00, 0);
    // output FIFO: fill, full write+read, overflow drop, ordered drain
    add(0, 8'h00, 0, 1, 8'h01, 0,   8'h00, 0, 0, 1, 1, 8'h01, 0);
    add(0, 8'h00, 0, 1, 8'h02, 0,   8'h00, 0, 0, 1, 1, 8'h01, 0);
    add(0, 8'h00, 0, 1, 8'h03, 0,   8'h00, 0, 0, 1, 1, 8'h01, 0);
    add(0, 8'h00, 0, 1, 8'h04, 0,   8'h00, 0, 0, 1, 1, 8'h01, 0);
    add(0, 8'h00, 0, 1, 8'h99, 1,   8'h00, 0, 0, 1, 1, 8'h02, 0);
    add(0, 8'h00, 0, 1, 8'h05, 0,   8'h00, 0, 0, 1, 1, 8'h02, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1,   8'h00, 0, 0, 1, 1, 8'h03, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1,   8'h00, 0, 0, 1, 1, 8'h04, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1,   8'h00, 0, 0, 1, 1, 8'h99, 1);
    add(0, 8'h00, 0, 0, 8'h00, 1,   8'h00, 0, 0, 1, 0, 8'h00, 1);

    // reset state while reset is held low
    repeat (2) @(posedge clk);
    #1;
    check_all("rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    reset = 1'b1;
    #1;
    chk("rst_release ext_in_ready", int'(ext_in_ready), 1);

    for (int i = 0; i < vecs.size(); i++) begin
      ext_in_valid  = vecs[i].v;
      ext_in_data   = vecs[i].d;
      in_rd         = vecs[i].rd;
      out_wr        = vecs[i].wr;
      cpu_out       = vecs[i].co;
      ext_out_ready = vecs[i].ordy;
      tick();
      check_all($sformatf("v%0d", i), vecs[i].e_ip, vecs[i].e_cnt, vecs[i].e_irq,
                vecs[i].e_irdy, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_oflo);
    end

    // async reset in the middle of an interrupt pulse with data buffered both ways
    ext_in_valid = 1'b1; ext_in_data = 8'hE1; in_rd = 1'b0;
    out_wr = 1'b1; cpu_out = 8'h5A; ext_out_ready = 1'b0;
    tick();
    chk("mid E1 interrupt", int'(interrupt), 1);
    ext_in_data = 8'hE2; out_wr = 1'b0;
    tick();
    check_all("mid E2", 8'hE1, 3'd2, 1'b1, 1'b1, 1'b1, 8'h5A, 1'b1);
    ext_in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    check_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b1;
    #1;
    chk("post_rst ext_in_ready", int'(ext_in_ready), 1);
    chk("post_rst input_port",   int'(input_port),   0);
    chk("post_rst in_count",     int'(in_count),     0);
    tick();
    chk("post_rst irq c1", int'(interrupt), 0);
    tick();
    chk("post_rst irq c2", int'(interrupt), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_io_peripheral.md
Name: cpu_io_peripheral

Overview:
- External-side I/O device that sits at the CPU's port boundary and implements the far end of the CPU I/O interface.
- Input path: buffers bytes arriving from an external source, presents the oldest byte on the CPU's input_port and raises the CPU interrupt when new data arrives.
- Output path: captures bytes the CPU writes to its OUT port into a FIFO, which an external consumer drains through a valid/ready handshake.

Parameters:
- IN_DEPTH, 4, input FIFO entries; power of 2, ≥2.
- OUT_DEPTH, 4, output FIFO entries; power of 2, ≥2.
- IRQ_CYCLES, 2, width of the interrupt pulse in clk cycles; ≥1.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- ext_in_data  in  8  byte from the external source.
- ext_in_valid  in  1  ext_in_data is valid.
- ext_in_ready  out  1  peripheral accepts a byte this cycle.
- input_port  out  8  to CPU input_port: head of the input FIFO.
- in_rd  in  1  CPU IN-instruction strobe, one cycle; pops the input FIFO head.
- interrupt  out  1  to CPU interrupt pin.
- cpu_out  in  8  from CPU OUT port.
- out_wr  in  1  CPU OUT-instruction strobe, one cycle; captures cpu_out.
- ext_out_data  out  8  head of the output FIFO.
- ext_out_valid  out  1  output FIFO non-empty.
- ext_out_ready  in  1  external consumer takes ext_out_data.
- in_count  out  $clog2(IN_DEPTH)+1  input FIFO occupancy.
- out_overflow  out  1  sticky flag: a CPU write was dropped.

Behaviour:
- Reset (reset=0, async):
  - Both FIFOs empty; pointers and counts 0.
  - FSM = IDLE; interrupt=0; out_overflow=0; input_port=8'h00; ext_out_valid=0; ext_out_data=8'h00; in_count=0.
  - ext_in_ready=0 while reset is low.
  - Reset mid-burst discards all buffered data; no partial interrupt pulse survives.
- Input FIFO:
  - push = ext_in_valid & ext_in_ready; ext_in_ready = reset & (in_count != IN_DEPTH).
  - pop = in_rd & (in_count != 0); in_rd while empty is ignored, no state change.
  - input_port = head byte when non-empty, else 8'h00. A byte pushed at edge N is visible on input_port after edge N if the FIFO was empty.
  - Simultaneous push and pop: both take effect; in_count unchanged.
  - Empty with push and in_rd in the same cycle: pop ignored; the byte remains.
  - Pointers wrap modulo IN_DEPTH.
- Interrupt FSM, registered output:
  - IDLE: a push while in_count==0 -> PULSE at that edge; cycle counter loads IRQ_CYCLES.
  - PULSE: interrupt=1; counter decrements each cycle; at counter==1 -> WAIT.
  - WAIT: interrupt=0; when in_count==0 after the edge -> IDLE.
  - Net effect: exactly one pulse per empty->non-empty burst. interrupt is high in cycles N+1 .. N+IRQ_CYCLES after a push at edge N.
  - If the FIFO drains during PULSE, the pulse still completes its full width, then WAIT immediately returns to IDLE.
- Output FIFO:
  - wr = out_wr; rd = ext_out_valid & ext_out_ready.
  - ext_out_valid = (count != 0); ext_out_data = head, 8'h00 when empty.
  - Full with wr and no rd: byte dropped, out_overflow <= 1; it stays 1 until reset.
  - Full with wr and rd in the same cycle: both accepted, count unchanged, no overflow.
  - Empty with wr: ext_out_valid rises the cycle after the edge (registered storage). The byte is not forwarded combinationally.
  - Pointers wrap modulo OUT_DEPTH.

Test Plan:
- Reset release, then push 8'hFD with ext_in_valid=1 for one cycle -> input_port=8'hFD, in_count=1; interrupt=1 for exactly 2 cycles, then 0; no second pulse while 8'hFD remains unread.
- Push 8'h11, 8'h22, 8'h33, 8'h44 -> ext_in_ready=0 after the 4th; a 5th byte 8'h55 held valid is not accepted. in_rd pops 8'h11 -> ready=1, 8'h55 accepted the next cycle, FIFO order 22,33,44,55.
- Drain the FIFO with 4 in_rd strobes, then push 8'hA0 -> a new 2-cycle interrupt pulse. in_rd while empty -> in_count stays 0, input_port=8'h00.
- With ext_out_ready=0, out_wr with cpu_out = 01,02,03,04,05 -> ext_out_valid=1, out_overflow=1, FIFO holds 01..04. Raise ext_out_ready -> 01,02,03,04 delivered in order, then valid=0.
- Output FIFO full, out_wr=1 with cpu_out=8'h99 and ext_out_ready=1 in the same cycle -> head popped, 8'h99 enqueued, out_overflow unchanged.
- Assert reset=0 asynchronously during an interrupt pulse with 3 bytes buffered -> interrupt, in_count and ext_out_valid drop immediately. After release: input_port=8'h00, ext_in_ready=1.
